// File: rtl/avst_adder_arbiter_pkg.sv
// Shared types for the adder arbiter: FSM state encoding and stream beat width.
package avst_adder_arbiter_pkg;

    localparam int BEAT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FWD  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/avst_adder_arbiter_if.sv
// Bundle of requester, adder sink/source and consumer streams around the arbiter.
// master = surrounding system (requesters, adder, consumer); slave = the arbiter.
interface avst_adder_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import avst_adder_arbiter_pkg::*;

    localparam int CH_W = $clog2(NUM_REQ);

    logic [BEAT_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_end;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;

    logic [BEAT_W-1:0]         add_data;
    logic                      add_end;
    logic                      add_valid;
    logic                      add_ready;

    logic [BEAT_W-1:0]         res_data;
    logic                      res_end;
    logic                      res_valid;
    logic                      res_ready;

    logic [BEAT_W-1:0]         out_data;
    logic                      out_end;
    logic [CH_W-1:0]           out_channel;
    logic                      out_valid;
    logic                      out_ready;

    logic                      err_orphan;

    modport master (
        output req_data, req_end, req_valid, add_ready,
        output res_data, res_end, res_valid, out_ready,
        input  req_ready, add_data, add_end, add_valid, res_ready,
        input  out_data, out_end, out_channel, out_valid, err_orphan
    );

    modport slave (
        input  req_data, req_end, req_valid, add_ready,
        input  res_data, res_end, res_valid, out_ready,
        output req_ready, add_data, add_end, add_valid, res_ready,
        output out_data, out_end, out_channel, out_valid, err_orphan
    );

endinterface

// File: rtl/avst_adder_arbiter_tag_fifo.sv
// Small synchronous FIFO of channel tags; head valid combinationally, one-cycle push-to-head.
// No internal backpressure: caller must not push when full or pop when empty.
module avst_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // Storage is not reset, so hide stale entries behind empty.
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/avst_adder_arbiter.sv
// Packet-level round-robin arbiter sharing one adder; grant one cycle after valid in IDLE, beats and results pass combinationally.
// Granted requester sees add_ready directly; result stream stalls on out_ready or when no tag is outstanding.
module avst_adder_arbiter
    import avst_adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    avst_adder_arbiter_if.slave bus
);
    localparam int CH_W = $clog2(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [CH_W-1:0]    g;
    logic [CH_W-1:0]    rr;
    logic               err_orphan_q;

    logic               grant;
    logic               end_xfer;
    logic               tag_full;
    logic               tag_empty;
    logic [CH_W-1:0]    tag_head;
    logic               res_ready_v;
    logic               tag_pop;

    logic [NUM_REQ-1:0] req_ready_v;
    logic [BEAT_W-1:0]  add_data_v;
    logic               add_end_v;
    logic               add_valid_v;

    // Lowest offset from ptr wins, wrapping modulo NUM_REQ.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [CH_W-1:0]    ptr);
        logic [CH_W-1:0] pick;
        int              idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx]) begin
                pick = CH_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] i);
        return (i == CH_W'(NUM_REQ - 1)) ? '0 : i + CH_W'(1);
    endfunction

    assign grant    = (state == IDLE) && (|bus.req_valid) && !tag_full;
    assign end_xfer = (state == FWD) && add_valid_v && bus.add_ready && add_end_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            g            <= '0;
            rr           <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                g <= rr_pick(bus.req_valid, rr);
            end
            if (end_xfer) begin
                rr <= next_idx(g);
            end
            if (bus.res_valid && tag_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)    state_nxt = FWD;
            FWD:     if (end_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_v = '0;
        add_data_v  = '0;
        add_end_v   = 1'b0;
        add_valid_v = 1'b0;
        if (state == FWD) begin
            add_data_v     = bus.req_data[int'(g)*BEAT_W +: BEAT_W];
            add_end_v      = bus.req_end[g];
            add_valid_v    = bus.req_valid[g];
            req_ready_v[g] = bus.add_ready;
        end
    end

    avst_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (CH_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (end_xfer),
        .push_data (g),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign res_ready_v = bus.out_ready && !tag_empty;
    assign tag_pop     = bus.res_valid && res_ready_v && bus.res_end;

    assign bus.req_ready   = req_ready_v;
    assign bus.add_data    = add_data_v;
    assign bus.add_end     = add_end_v;
    assign bus.add_valid   = add_valid_v;
    assign bus.res_ready   = res_ready_v;
    assign bus.out_data    = bus.res_data;
    assign bus.out_end     = bus.res_end;
    assign bus.out_channel = tag_head;
    assign bus.out_valid   = bus.res_valid && !tag_empty;
    assign bus.err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_avst_adder_arbiter.sv
// Bench for avst_adder_arbiter: plays requesters, adder and consumer; checks arbitration, tagging and error flag.
module tb_avst_adder_arbiter;
    import avst_adder_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TD = 2;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avst_adder_arbiter_if #(.NUM_REQ(N)) bus ();

    avst_adder_arbiter #(.NUM_REQ(N), .TAG_DEPTH(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         prev;
        logic [3:0] mask;
        logic [3:0] rdy;
        int         g;
    } arb_vec_t;

    arb_vec_t av [7];

    logic [7:0] pb   [N][NP][3];
    int         plen [N][NP];
    int         pk [N];
    int         bt [N];
    int         mdone [N];
    int         mrr;
    logic [7:0] cur [$];
    logic [7:0] rq [$];
    int         rch [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_data  = '0;
        bus.req_end   = '0;
        bus.req_valid = '0;
        bus.add_ready = 1'b0;
        bus.res_data  = '0;
        bus.res_end   = 1'b0;
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Bytes are taken MSB-first from the 24-bit argument.
    task automatic send_beats(input int r, input int n, input logic [23:0] bytes);
        for (int k = 0; k < n; k++) begin
            logic [7:0] bv;
            int         waited;
            bv = bytes[23-8*k -: 8];
            bus.req_data[8*r +: 8] = bv;
            bus.req_end[r]         = (k == n - 1);
            bus.req_valid[r]       = 1'b1;
            waited = 0;
            @(negedge clk);
            while (!bus.req_ready[r] && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            check("beat_accept", bus.req_ready[r], 1);
            check("add_beat", {bus.add_end, bus.add_data}, {(k == n - 1), bv});
            @(posedge clk);
            #1;
        end
        bus.req_valid[r] = 1'b0;
        bus.req_end[r]   = 1'b0;
    endtask

    task automatic return_result(input logic [31:0] sum, input int ch);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] bv;
            bv = sum[31-8*k -: 8];
            bus.res_data  = bv;
            bus.res_end   = (k == 3);
            bus.res_valid = 1'b1;
            @(negedge clk);
            check("result_beat",
                  {bus.out_valid, bus.res_ready, bus.out_end, bus.out_channel, bus.out_data},
                  {1'b1, 1'b1, (k == 3), 2'(ch), bv});
            @(posedge clk);
            #1;
        end
        bus.res_valid = 1'b0;
        bus.res_end   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int acc [3];
        int cyc;
        int rbeat;
        int total;

        av[0] = '{-1, 4'b0001, 4'b0001, 0};
        av[1] = '{-1, 4'b1010, 4'b0010, 1};
        av[2] = '{ 1, 4'b1001, 4'b1000, 3};
        av[3] = '{ 3, 4'b1100, 4'b0100, 2};
        av[4] = '{ 2, 4'b0111, 4'b0001, 0};
        av[5] = '{ 0, 4'b0011, 4'b0010, 1};
        av[6] = '{ 0, 4'b0001, 4'b0001, 0};

        // Reset values, sampled while reset is held.
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_add", {bus.add_valid, bus.add_end, bus.add_data}, 0);
        check("rst_res_ready", bus.res_ready, 0);
        check("rst_out", {bus.out_valid, bus.out_end, bus.out_channel}, 0);
        check("rst_err", bus.err_orphan, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single 3-beat packet from requester 0, then its sum result.
        bus.add_ready    = 1'b1;
        bus.req_valid[0] = 1'b1;
        bus.req_data[7:0] = 8'h01;
        @(negedge clk);
        check("idle_no_fwd", {bus.req_ready, bus.add_valid}, 0);
        @(posedge clk);
        #1;
        send_beats(0, 3, 24'h010203);
        return_result(32'h0000_0006, 0);

        // Arbitration table: prev packet sets the round-robin pointer.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            bus.add_ready = 1'b1;
            if (av[v].prev >= 0) begin
                send_beats(av[v].prev, 1, 24'h100000);
            end
            bus.req_valid = av[v].mask;
            bus.req_end   = av[v].mask;
            for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = 8'hA0 + 8'(i);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("arb_vec%0d_rdy", v), bus.req_ready, av[v].rdy);
            check($sformatf("arb_vec%0d_dat", v), bus.add_data, 8'hA0 + 8'(av[v].g));
            @(posedge clk);
            #1;
            idle_inputs();
        end

        // Adder stalls 5 cycles mid-packet; requester 2 must wait.
        do_reset();
        bus.add_ready     = 1'b1;
        bus.req_valid     = 4'b0110;
        bus.req_end       = 4'b0100;
        bus.req_data      = 32'h0022_1100;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_first", {bus.req_ready, bus.add_data}, {4'b0010, 8'h11});
        @(posedge clk);
        #1;
        bus.req_data[15:8] = 8'h12;
        bus.req_end[1]     = 1'b1;
        bus.add_ready      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_hold", {bus.req_ready, bus.add_valid, bus.add_end, bus.add_data},
                  {4'b0000, 1'b1, 1'b1, 8'h12});
            @(posedge clk);
            #1;
        end
        bus.add_ready = 1'b1;
        @(negedge clk);
        check("stall_release", {bus.req_ready, bus.add_data}, {4'b0010, 8'h12});
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        check("stall_bubble", bus.req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_next_grant", bus.req_ready, 4'b0100);
        @(posedge clk);
        #1;

        // Tag FIFO full: third single-beat packet waits for the first result.
        do_reset();
        bus.add_ready = 1'b1;
        bus.req_valid = 4'b0111;
        bus.req_end   = 4'b0111;
        bus.req_data  = 32'h0032_3130;
        acc = '{0, 0, 0};
        for (int c = 0; c < 12; c++) begin
            logic [2:0] took;
            @(negedge clk);
            took = bus.req_ready[2:0] & bus.req_valid[2:0];
            for (int i = 0; i < 3; i++) acc[i] += int'(took[i]);
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (took[i]) bus.req_valid[i] = 1'b0;
        end
        check("tagfull_grants", {acc[2][7:0], acc[1][7:0], acc[0][7:0]}, 24'h00_01_01);
        return_result(32'h0000_0030, 0);
        @(negedge clk);
        check("tagfull_bubble", bus.req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("tagfull_third", bus.req_ready, 4'b0100);
        @(posedge clk);
        #1;

        // Orphan result: stalled, error sticky until reset.
        do_reset();
        bus.res_valid = 1'b1;
        bus.res_end   = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("orphan_stall", {bus.res_ready, bus.out_valid, bus.err_orphan}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("orphan_flag", {bus.res_ready, bus.err_orphan}, 2'b01);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("orphan_sticky", bus.err_orphan, 1);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("orphan_cleared", bus.err_orphan, 0);
        @(posedge clk);
        #1;

        // Randomized traffic against a queue-level round-robin model.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pk[i] = 0;
            bt[i] = 0;
            mdone[i] = 0;
            for (int p = 0; p < NP; p++) begin
                plen[i][p] = $urandom_range(1, 3);
                for (int b = 0; b < 3; b++) pb[i][p][b] = 8'($urandom);
            end
        end
        mrr   = 0;
        cyc   = 0;
        rbeat = 0;
        total = 0;
        cur.delete();
        rq.delete();
        rch.delete();
        while ((total < N * NP || rq.size() > 0) && cyc < 5000) begin
            for (int i = 0; i < N; i++) begin
                if (pk[i] < NP) begin
                    bus.req_valid[i]       = (bt[i] == 0) || ($urandom_range(0, 3) != 0);
                    bus.req_data[8*i +: 8] = pb[i][pk[i]][bt[i]];
                    bus.req_end[i]         = (bt[i] == plen[i][pk[i]] - 1);
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_end[i]         = 1'b0;
                end
            end
            bus.add_ready = ($urandom_range(0, 3) != 0);
            bus.res_valid = (rq.size() > 0) && ($urandom_range(0, 2) != 0);
            bus.res_data  = (rq.size() > 0) ? rq[0] : 8'h00;
            bus.res_end   = (rbeat == 3);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    if (bus.req_end[i]) begin
                        pk[i]++;
                        bt[i] = 0;
                    end else begin
                        bt[i]++;
                    end
                end
            end
            if (bus.add_valid && bus.add_ready) begin
                cur.push_back(bus.add_data);
                if (bus.add_end) begin
                    int          eg;
                    logic        ok;
                    logic [31:0] sum;
                    eg = -1;
                    for (int k = 0; k < N; k++) begin
                        int j;
                        j = (mrr + k) % N;
                        if (eg < 0 && mdone[j] < NP) eg = j;
                    end
                    ok = (eg >= 0);
                    if (ok) begin
                        ok = (cur.size() == plen[eg][mdone[eg]]);
                        for (int b = 0; b < cur.size() && b < 3; b++)
                            if (cur[b] !== pb[eg][mdone[eg]][b]) ok = 1'b0;
                    end
                    check("rand_pkt", ok, 1);
                    if (eg >= 0) begin
                        sum = 0;
                        foreach (cur[b]) sum += 32'(cur[b]);
                        for (int b = 0; b < 4; b++) begin
                            rq.push_back(sum[31-8*b -: 8]);
                            rch.push_back(eg);
                        end
                        mdone[eg]++;
                        mrr = (eg + 1) % N;
                    end
                    total++;
                    cur.delete();
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                check("rand_out", {bus.out_valid, bus.out_ready, bus.out_end, bus.out_channel, bus.out_data},
                      {1'b1, 1'b1, (rbeat == 3), 2'(rch[0]), rq[0]});
                void'(rq.pop_front());
                void'(rch.pop_front());
                rbeat = (rbeat + 1) % 4;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand_done", {total[15:0], rq.size() == 0}, {16'(N * NP), 1'b1});
        check("rand_no_orphan", bus.err_orphan, 0);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avst_adder_arbiter.md
# avst_adder_arbiter

Packet-level round-robin arbiter that shares one 8-bit Avalon-ST packet adder (sum-of-bytes, 4-byte big-endian result packet) among NUM_REQ requesting streams. It grants one requester at a time, holds the grant until that requester's end-of-packet beat is accepted, and forwards the adder's request beats combinationally. It tags every packet sent to the adder and returns the adder's result packet on a single output stream, labelled with the originating channel.

## Interface
- NUM_REQ, 4, number of requesting streams (2..8)
- TAG_DEPTH, 2, depth of the outstanding-packet tag FIFO (power of 2, ≥1)
- CH_W, $clog2(NUM_REQ), channel index width (derived)

- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req_data  in  8*NUM_REQ  request data; byte i is requester i
- req_end  in  NUM_REQ  last beat of the requester's packet
- req_valid  in  NUM_REQ  requester beat valid
- req_ready  out  NUM_REQ  beat accepted from requester
- add_data  out  8  data to adder sink
- add_end  out  1  end-of-packet to adder
- add_valid  out  1  valid to adder
- add_ready  in  1  adder sink ready
- res_data  in  8  adder result byte
- res_end  in  1  adder result end-of-packet
- res_valid  in  1  adder result valid
- res_ready  out  1  ready to adder source
- out_data  out  8  result byte to consumer
- out_end  out  1  result end-of-packet
- out_channel  out  CH_W  requester index the result belongs to
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- err_orphan  out  1  sticky: result beat arrived with no outstanding tag

## Operation
- FSM states: IDLE, FWD. Registers: grant index g, round-robin pointer rr, tag FIFO (TAG_DEPTH x CH_W, count), err_orphan.
- IDLE: if any req_valid and tag FIFO not full, g <= first requester with valid at or after rr (wrapping modulo NUM_REQ); go to FWD. Otherwise stay. No beats forwarded in IDLE.
- FWD: add_data/add_end/add_valid = req_data[g]/req_end[g]/req_valid[g]; req_ready[g] = add_ready; all other req_ready = 0. Transfer = add_valid && add_ready.
- Transfer with add_end=1: push g to tag FIFO, rr <= (g+1) mod NUM_REQ, go to IDLE.
- Result path (independent of FSM): out_data = res_data, out_end = res_end, out_channel = tag FIFO head, out_valid = res_valid && !tag_empty, res_ready = out_ready && !tag_empty. Transfer with res_end=1 pops the tag.
- Push and pop in the same cycle: both applied, count unchanged. Push never occurs when full (grant gated in IDLE).
- res_valid=1 while tag FIFO empty: res_ready stays 0 (stall, no drop) and err_orphan <= 1 until reset.
- Reset mid-packet: FSM to IDLE, rr=0, tag FIFO emptied, err_orphan=0; partially forwarded packet is abandoned (the adder is reset on the same reset).

## Timing
- Reset values: req_ready=0, add_valid=0, add_end=0, add_data=0, res_ready=0, out_valid=0, out_end=0, out_channel=0, err_orphan=0.
- Arbitration: valid seen in IDLE at cycle t -> FWD at t+1; first beat forwardable at t+1.
- Forwarding and result paths are combinational, zero latency.
- End beat accepted at t -> IDLE at t+1 -> next grant at t+2 (one bubble per packet minimum).
- Single-beat packet (end on first beat) is legal: one beat, one tag.
- A requester dropping valid mid-packet keeps the grant; the arbiter never pre-empts.

## Structure
- Shared package: FSM state enum (IDLE, FWD), AVST beat width constant (8).
- One natural sub-module: avst_tag_fifo (synchronous FIFO, push/pop/full/empty/head).
- Round-robin selection is a function in the top module.

## Test plan
- Single requester 0 sends 0x01,0x02,0x03(end) -> adder sees 3 beats; result 0x00,0x00,0x00,0x06(end) emitted with out_channel=0.
- Requesters 0..3 all valid continuously, 2-beat packets -> grants in order 0,1,2,3,0; out_channel sequence 0,1,2,3.
- rr=2, only requesters 0 and 3 valid -> grant 3 first, then 0.
- Adder holds add_ready=0 for 5 cycles mid-packet -> req_ready[g]=0 for those cycles, no beat lost or duplicated; other requesters never granted.
- TAG_DEPTH=2, consumer out_ready=0, three packets sent -> third grant withheld until the first result end beat is transferred.
- res_valid=1 asserted after reset with no packet sent -> res_ready=0, err_orphan=1 next cycle and stays 1 until reset.
